// File: rtl/jt051937_draw.sv
// Sprite tile-row drawer: fetches one 16-pixel 4bpp row from ROM, then writes the
// horizontally zoomed and flipped opaque pixels into the line buffer.
module jt051937_draw #(
    parameter int          MAXPXL    = 256,
    parameter logic [11:0] ZERO_STEP = 12'h040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        dr_start,
    output logic        dr_busy,
    input  logic [15:0] code,
    input  logic [6:0]  attr,
    input  logic        hflip,
    input  logic [8:0]  hpos,
    input  logic [3:0]  ysub,
    input  logic [11:0] hzoom,
    input  logic        hz_keep,
    output logic [20:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic [8:0]  buf_addr,
    output logic [10:0] buf_din,
    output logic        buf_we
);
    localparam int CW = $clog2(MAXPXL + 1);

    typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, DRAW, DONE} state_t;

    state_t          state, state_nx;
    logic [15:0]     code_l;
    logic [3:0]      ysub_l;
    logic [6:0]      attr_l;
    logic            hflip_l, keep_l;
    logic [8:0]      hpos_l;
    logic [11:0]     step_l;
    logic [15:0][3:0] row;
    logic [9:0]      acc;
    logic [8:0]      xcur;
    logic [CW-1:0]   cnt;
    logic [12:0]     sum;
    logic [3:0]      src, pix;
    logic            fetch_ok, draw_end;

    // Wide sum so very large steps still register as crossing the tile end.
    always_comb begin
        sum      = 13'(acc) + 13'(step_l);
        src      = hflip_l ? ~acc[9:6] : acc[9:6];
        pix      = row[src];
        fetch_ok = rom_cs & rom_ok;
        draw_end = (sum >= 13'd1024) || (cnt == CW'(MAXPXL - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cen) begin
            case (state)
                IDLE:    if (dr_start) state_nx = FETCH0;
                FETCH0:  if (fetch_ok) state_nx = FETCH1;
                FETCH1:  if (fetch_ok) state_nx = DRAW;
                DRAW:    if (draw_end) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_busy  <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            buf_addr <= '0;
            buf_din  <= '0;
            buf_we   <= 1'b0;
            acc      <= '0;
            xcur     <= '0;
            cnt      <= '0;
            code_l   <= '0;
            ysub_l   <= '0;
            attr_l   <= '0;
            hflip_l  <= 1'b0;
            keep_l   <= 1'b0;
            hpos_l   <= '0;
            step_l   <= '0;
            row      <= '0;
        end else if (cen) begin
            buf_we <= 1'b0;
            case (state)
                IDLE: if (dr_start) begin
                    code_l   <= code;
                    ysub_l   <= ysub;
                    attr_l   <= attr;
                    hflip_l  <= hflip;
                    keep_l   <= hz_keep;
                    hpos_l   <= hpos;
                    step_l   <= (hzoom == 12'd0) ? ZERO_STEP : hzoom;
                    dr_busy  <= 1'b1;
                    rom_cs   <= 1'b1;
                    rom_addr <= {code, ysub, 1'b0};
                end
                FETCH0: if (fetch_ok) begin
                    row[7:0] <= rom_data;
                    rom_addr <= {code_l, ysub_l, 1'b1};
                end
                FETCH1: if (fetch_ok) begin
                    row[15:8] <= rom_data;
                    rom_cs    <= 1'b0;
                    cnt       <= '0;
                    // A continued tile inherits the leftover fraction and x position.
                    if (!keep_l) begin
                        acc  <= '0;
                        xcur <= hpos_l;
                    end
                end
                DRAW: begin
                    buf_addr <= xcur;
                    buf_din  <= {attr_l, pix};
                    buf_we   <= (pix != 4'd0);
                    xcur     <= xcur + 1'b1;
                    acc      <= sum[9:0];
                    cnt      <= cnt + 1'b1;
                end
                DONE:    dr_busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jt051937_draw.sv
// Scoreboard bench for jt051937_draw: stimulus queues expected ROM addresses and
// line-buffer writes, a monitor pops and compares them as the DUT produces them.
module tb_jt051937_draw;
    logic        clk, rst_n, cen, dr_start, dr_busy, hflip, hz_keep;
    logic [15:0] code;
    logic [6:0]  attr;
    logic [8:0]  hpos, buf_addr;
    logic [3:0]  ysub;
    logic [11:0] hzoom;
    logic [20:0] rom_addr;
    logic        rom_cs, rom_ok, buf_we;
    logic [31:0] rom_data;
    logic [10:0] buf_din;

    jt051937_draw dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .dr_start(dr_start), .dr_busy(dr_busy),
        .code(code), .attr(attr), .hflip(hflip), .hpos(hpos), .ysub(ysub),
        .hzoom(hzoom), .hz_keep(hz_keep), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .rom_data(rom_data), .buf_addr(buf_addr), .buf_din(buf_din),
        .buf_we(buf_we)
    );

    // cen is high on every other rising edge; it flips just after each edge
    initial begin
        clk = 0; cen = 0;
        forever begin #5 clk = 1; #1 cen = ~cen; #4 clk = 0; end
    end

    // ROM: data valid once the address has been stable rom_delay clocks
    logic [31:0] rom_lo, rom_hi;
    int          rom_delay = 0;
    logic [20:0] addr_q;
    logic        cs_q;
    int          wcnt;
    always @(posedge clk) begin
        cs_q <= rom_cs;
        if (!rom_cs || !cs_q || rom_addr != addr_q) begin
            addr_q <= rom_addr;
            wcnt   <= 0;
        end else if (wcnt < 1000) wcnt <= wcnt + 1;
    end
    assign rom_ok   = rom_cs && cs_q && (rom_addr == addr_q) && (wcnt >= rom_delay);
    assign rom_data = rom_addr[0] ? rom_hi : rom_lo;

    int          errors = 0, checks = 0, wr_seen = 0, tile_w0 = 0;
    logic [19:0] wq[$];
    logic [20:0] rq[$];
    int          m_acc = 0;
    logic [8:0]  m_x = 0;
    logic [3:0]  t1 [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 9, 10, 11, 12, 13, 14, 15};
    logic [3:0]  t3 [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 9, 10, 11, 12, 13, 14, 15};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step_cen();
        do @(negedge clk); while (cen);
    endtask

    initial begin : monitor
        logic       mon_cs;
        logic [20:0] mon_addr;
        mon_cs = 0; mon_addr = 0;
        forever begin
            step_cen();
            if (rst_n) begin
                if (buf_we) begin
                    wr_seen++;
                    if (wq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL write: unexpected x=%h din=%h", buf_addr, buf_din);
                    end else chk("write", {12'd0, buf_addr, buf_din}, {12'd0, wq.pop_front()});
                end
                if (rom_cs && (!mon_cs || rom_addr != mon_addr)) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rom_addr: unexpected %h", rom_addr);
                    end else chk("rom_addr", {11'd0, rom_addr}, {11'd0, rq.pop_front()});
                end
            end
            mon_cs = rom_cs; mon_addr = rom_addr;
        end
    end

    // Expected writes of one tile from the zoom rules, continuing m_acc/m_x on keep
    task automatic push_model(input logic [15:0] c, input logic [3:0] ys, input logic [6:0] at,
                              input logic hf, input logic [8:0] hp, input logic [11:0] hz,
                              input logic kp);
        int st, s, sum, n;
        logic [63:0] r;
        logic [3:0]  p;
        logic        fin;
        r  = {rom_hi, rom_lo};
        st = (hz == 0) ? 64 : int'(hz);
        rq.push_back({c, ys, 1'b0});
        rq.push_back({c, ys, 1'b1});
        if (!kp) begin m_acc = 0; m_x = hp; end
        n = 0;
        do begin
            s = m_acc / 64;
            if (hf) s = 15 - s;
            p = r[4*s +: 4];
            if (p != 0) wq.push_back({m_x, at, p});
            m_x   = m_x + 9'd1;
            sum   = m_acc + st;
            n++;
            m_acc = sum % 1024;
            fin   = (sum >= 1024) || (n >= 256);
        end while (!fin);
    endtask

    task automatic start_tile(input logic [15:0] c, input logic [3:0] ys, input logic [6:0] at,
                              input logic hf, input logic [8:0] hp, input logic [11:0] hz,
                              input logic kp);
        step_cen();
        tile_w0 = wr_seen;
        code = c; ysub = ys; attr = at; hflip = hf; hpos = hp; hzoom = hz; hz_keep = kp;
        dr_start = 1;
        step_cen();
        dr_start = 0;
        chk("busy_rise", {31'd0, dr_busy}, 1);
    endtask

    task automatic finish_tile(input int exp_n, input string nm, output int lat);
        lat = -1;
        for (int k = 1; k <= 600; k++) begin
            step_cen();
            if (buf_we && lat < 0) lat = k;
            if (!dr_busy) break;
        end
        chk({nm, " busy_fall"}, {31'd0, dr_busy}, 0);
        step_cen();
        chk({nm, " strobes"}, wr_seen - tile_w0, exp_n);
        chk({nm, " drained"}, wq.size() + rq.size(), 0);
    endtask

    initial begin
        int lat, w0;
        rst_n = 0; dr_start = 0; code = 0; attr = 0; hflip = 0; hpos = 0; ysub = 0;
        hzoom = 0; hz_keep = 0;
        rom_lo = 32'h87654321; rom_hi = 32'hFEDCBA90;
        repeat (3) step_cen();
        chk("rst dr_busy", {31'd0, dr_busy}, 0);
        chk("rst rom_cs", {31'd0, rom_cs}, 0);
        chk("rst buf_we", {31'd0, buf_we}, 0);
        chk("rst outputs", {rom_addr, buf_addr, buf_din}, 0);
        rst_n = 1;

        // 1:1, no flip: pixels 1..8, transparent, 9..F at x=0x20..0x2F
        rq.push_back(21'h24686); rq.push_back(21'h24687);
        for (int i = 0; i < 16; i++)
            if (t1[i] != 0) wq.push_back({9'h020 + 9'(i), 7'h55, t1[i]});
        start_tile(16'h1234, 4'h3, 7'h55, 0, 9'h020, 12'h040, 0);
        finish_tile(15, "plain", lat);
        chk("first write latency", lat, 3);

        // mirrored
        rq.push_back(21'h24686); rq.push_back(21'h24687);
        for (int i = 0; i < 16; i++)
            if (t1[15-i] != 0) wq.push_back({9'h020 + 9'(i), 7'h2A, t1[15-i]});
        start_tile(16'h1234, 4'h3, 7'h2A, 1, 9'h020, 12'h040, 0);
        finish_tile(15, "hflip", lat);

        // 2x enlarge, then a continued tile picks up at x=0x40 with acc=0
        rom_hi = 32'hFEDCBA91;
        push_model(16'h0100, 4'h0, 7'h11, 0, 9'h020, 12'h020, 0);
        start_tile(16'h0100, 4'h0, 7'h11, 0, 9'h020, 12'h020, 0);
        finish_tile(32, "zoom2x", lat);
        rq.push_back({16'h0101, 4'h0, 1'b0}); rq.push_back({16'h0101, 4'h0, 1'b1});
        for (int i = 0; i < 32; i++) wq.push_back({9'h040 + 9'(i), 7'h12, t3[i/2]});
        start_tile(16'h0101, 4'h0, 7'h12, 0, 9'h100, 12'h020, 1);
        finish_tile(32, "zoom2x keep", lat);

        // 1.5 px step: 11 pixels, then 11 more from acc=0x20 (one transparent)
        rom_hi = 32'hFEDCBA90;
        push_model(16'h0200, 4'h7, 7'h33, 0, 9'h080, 12'h060, 0);
        start_tile(16'h0200, 4'h7, 7'h33, 0, 9'h080, 12'h060, 0);
        finish_tile(11, "shrink", lat);
        push_model(16'h0201, 4'h7, 7'h33, 0, 9'h000, 12'h060, 1);
        start_tile(16'h0201, 4'h7, 7'h33, 0, 9'h000, 12'h060, 1);
        finish_tile(10, "shrink keep", lat);

        // slow ROM with a stray start pulse during the first fetch
        rom_delay = 5;
        push_model(16'h0ABC, 4'h5, 7'h44, 0, 9'h090, 12'h040, 0);
        start_tile(16'h0ABC, 4'h5, 7'h44, 0, 9'h090, 12'h040, 0);
        code = 16'h5555; hpos = 9'h1AA; hflip = 1; dr_start = 1;
        step_cen();
        dr_start = 0;
        chk("slow busy", {31'd0, dr_busy}, 1);
        chk("slow no write", {31'd0, buf_we}, 0);
        step_cen();
        chk("slow busy2", {31'd0, dr_busy}, 1);
        chk("slow no write2", {31'd0, buf_we}, 0);
        finish_tile(15, "slow rom", lat);
        rom_delay = 0;

        // hzoom=0 falls back to the 1:1 step
        push_model(16'h0300, 4'h1, 7'h01, 0, 9'h030, 12'h000, 0);
        start_tile(16'h0300, 4'h1, 7'h01, 0, 9'h030, 12'h000, 0);
        finish_tile(15, "zero step", lat);

        // tiny step capped by the write limit
        push_model(16'h0400, 4'h2, 7'h02, 0, 9'h000, 12'h001, 0);
        start_tile(16'h0400, 4'h2, 7'h02, 0, 9'h000, 12'h001, 0);
        finish_tile(256, "maxpxl", lat);

        // x wraps past 0x1FF
        rom_hi = 32'hFEDCBA91;
        push_model(16'h0500, 4'h9, 7'h03, 0, 9'h1FC, 12'h040, 0);
        start_tile(16'h0500, 4'h9, 7'h03, 0, 9'h1FC, 12'h040, 0);
        finish_tile(16, "wrap", lat);

        // reset in the middle of drawing
        push_model(16'h0600, 4'h0, 7'h04, 0, 9'h0C0, 12'h020, 0);
        start_tile(16'h0600, 4'h0, 7'h04, 0, 9'h0C0, 12'h020, 0);
        for (int k = 0; k < 20 && !buf_we; k++) step_cen();
        chk("rst drawing", {31'd0, buf_we}, 1);
        #2 rst_n = 0;
        #1;
        chk("rst mid buf_we", {31'd0, buf_we}, 0);
        chk("rst mid dr_busy", {31'd0, dr_busy}, 0);
        chk("rst mid rom_cs", {31'd0, rom_cs}, 0);
        wq.delete(); rq.delete(); m_acc = 0; m_x = 0;
        repeat (3) step_cen();
        rst_n = 1;
        w0 = wr_seen;
        repeat (10) step_cen();
        chk("rst no writes", wr_seen - w0, 0);
        chk("rst idle", {31'd0, dr_busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
